sram_sp_be: RTL and testbench

//  Parametrised single-port synchronous SRAM. Successor to the fixed 16x16 store.

---
 rtl/sram_sp_be.sv | 163 ++++++++++++++++
 tb/tb_sram_sp_be.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sp_be.sv
// Single-port byte-enable SRAM: valid/ready requests, 1- or 2-cycle read latency, zero-fill after reset.
// Define SRAM_BYTE_PARITY_EN to store an even-parity bit per byte and add the rd_perr output.

module sram_sp_be_lane #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic              rzero,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
`ifdef SRAM_BYTE_PARITY_EN
    ,
    input  logic              wpar,
    output logic              rerr
`endif
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only loaded on a read, so the value holds between reads.
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= rzero ? '0 : mem[raddr];
    end

`ifdef SRAM_BYTE_PARITY_EN
    logic par [DEPTH];

    always_ff @(posedge clk) begin
        if (we) par[waddr] <= wpar;
    end

    always_ff @(posedge clk) begin
        if (rst)     rerr <= 1'b0;
        else if (re) rerr <= rzero ? 1'b0 : (par[raddr] ^ (^mem[raddr]));
    end
`endif
endmodule

module sram_sp_be #(
    parameter int DATA_W       = 16,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  init_done
`ifdef SRAM_BYTE_PARITY_EN
    ,
    output logic                  rd_perr
`endif
);
    localparam int NB = DATA_W / 8;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sram_sp_be: READ_LATENCY must be 1 or 2");
    end
    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("sram_sp_be: DATA_W must be a multiple of 8");
    end

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t               state;
    logic [ADDR_W-1:0]    clr_ptr;
    logic                 clearing, acc, in_range, wr_acc, rd_acc;
    logic [ADDR_W-1:0]    waddr;
    logic [NB-1:0][7:0]   wbytes, s1_bytes;
    logic [NB-1:0]        lane_we;
    logic [READ_LATENCY:1] vld_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
            if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                state     <= IDLE;
                req_ready <= 1'b1;
                init_done <= 1'b1;
            end
        end
    end

    assign clearing = (state == CLEAR) && !rst;
    assign acc      = req_valid && req_ready && !rst;
    // Only reachable for non-power-of-2 DEPTH.
    assign in_range = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);
    assign wr_acc   = acc && req_we && in_range;
    assign rd_acc   = acc && !req_we;
    assign waddr    = clearing ? clr_ptr : req_addr;
    assign wbytes   = req_wdata;
    assign lane_we  = clearing ? '1 : ({NB{wr_acc}} & req_be);

`ifdef SRAM_BYTE_PARITY_EN
    logic [NB-1:0] s1_err;
`endif

    for (genvar i = 0; i < NB; i++) begin : g_lane
        sram_sp_be_lane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .we    (lane_we[i]),
            .waddr (waddr),
            .wdata (clearing ? 8'h00 : wbytes[i]),
            .re    (rd_acc),
            .rzero (!in_range),
            .raddr (req_addr),
            .rdata (s1_bytes[i])
`ifdef SRAM_BYTE_PARITY_EN
            ,
            .wpar  (clearing ? 1'b0 : ^wbytes[i]),
            .rerr  (s1_err[i])
`endif
        );
    end

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= READ_LATENCY'({vld_pipe, rd_acc});
    end

    assign rd_valid = vld_pipe[READ_LATENCY];

    if (READ_LATENCY == 1) begin : g_lat1
        assign rd_data = s1_bytes;
`ifdef SRAM_BYTE_PARITY_EN
        assign rd_perr = vld_pipe[1] && (|s1_err);
`endif
    end else begin : g_lat2
        always_ff @(posedge clk) begin
            if (rst)              rd_data <= '0;
            else if (vld_pipe[1]) rd_data <= s1_bytes;
        end
`ifdef SRAM_BYTE_PARITY_EN
        always_ff @(posedge clk) begin
            if (rst) rd_perr <= 1'b0;
            else     rd_perr <= vld_pipe[1] && (|s1_err);
        end
`endif
    end
endmodule

// File: tb/tb_sram_sp_be.sv
// Bench for sram_sp_be: two instances (16 words / latency 1, 12 words / latency 2) on shared stimulus,
// checked every cycle against an array model plus directed literal expectations.
module tb_sram_sp_be;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_we;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic [1:0]  rdy, rv, idn, perr;
    logic [15:0] rdat [2];

    sram_sp_be #(.DATA_W(16), .DEPTH(16), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rd_valid(rv[0]),
        .rd_data(rdat[0]), .init_done(idn[0])
`ifdef SRAM_BYTE_PARITY_EN
        , .rd_perr(perr[0])
`endif
    );

    sram_sp_be #(.DATA_W(16), .DEPTH(12), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rd_valid(rv[1]),
        .rd_data(rdat[1]), .init_done(idn[1])
`ifdef SRAM_BYTE_PARITY_EN
        , .rd_perr(perr[1])
`endif
    );

`ifndef SRAM_BYTE_PARITY_EN
    assign perr = 2'b00;
`endif

    int n_chk = 0, n_pass = 0;
    function automatic void chk(string nm, int inst, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h expected %h", nm, inst, act, exp);
    endfunction

    function automatic int dep(int i); return (i == 0) ? 16 : 12; endfunction
    function automatic int lat(int i); return (i == 0) ? 1 : 2; endfunction

    // Model: word array, fill counter, and a schedule of expected read results (index 0 = now).
    logic [15:0] mm [2][16];
    logic        bad [16];
    int          fill [2];
    logic        sv [2][4];
    logic [15:0] sd [2][4];
    logic        sp [2][4];
    logic [15:0] last_d [2];
    int          cyc = 0;
    bit          chk_on = 0;

    initial begin
        for (int a = 0; a < 16; a++) bad[a] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fill[i] = 0; last_d[i] = '0;
            for (int k = 0; k < 4; k++) begin sv[i][k] = 1'b0; sd[i][k] = '0; sp[i][k] = 1'b0; end
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 3; k++) begin
                    sv[i][k] = sv[i][k+1]; sd[i][k] = sd[i][k+1]; sp[i][k] = sp[i][k+1];
                end
                sv[i][3] = 1'b0; sd[i][3] = '0; sp[i][3] = 1'b0;
                if (rst) begin
                    fill[i] = 0;
                    last_d[i] = '0;
                    for (int k = 0; k < 4; k++) sv[i][k] = 1'b0;
                    for (int a = 0; a < 16; a++) mm[i][a] = '0;
                    if (i == 0) for (int a = 0; a < 16; a++) bad[a] = 1'b0;
                end else begin
                    if (req_valid && fill[i] >= dep(i)) begin
                        if (req_we) begin
                            if (int'(req_addr) < dep(i)) begin
                                for (int b = 0; b < 2; b++)
                                    if (req_be[b]) mm[i][req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
                                if (i == 0 && req_be != 2'b00) bad[req_addr] = 1'b0;
                            end
                        end else begin
                            sv[i][lat(i)-1] = 1'b1;
                            sd[i][lat(i)-1] = (int'(req_addr) < dep(i)) ? mm[i][req_addr] : 16'h0000;
                            sp[i][lat(i)-1] = (i == 0) && bad[req_addr];
                        end
                    end
                    if (fill[i] < dep(i)) fill[i]++;
                    if (sv[i][0]) last_d[i] = sd[i][0];
                end
            end
        end
    end

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                chk("rd_valid", i, 32'(rv[i]), 32'(sv[i][0]));
                chk("rd_data", i, 32'(rdat[i]), 32'(last_d[i]));
                chk("req_ready", i, 32'(rdy[i]), 32'(fill[i] >= dep(i)));
                chk("init_done", i, 32'(idn[i]), 32'(fill[i] >= dep(i)));
                chk("rd_perr", i, 32'(perr[i]), 32'(sv[i][0] && sp[i][0]));
            end
        end
    end

    typedef struct { int c; logic [15:0] d; logic p; } ev_t;
    ev_t log0[$], log1[$];
    initial forever begin
        @(negedge clk);
        if (rv[0]) log0.push_back('{cyc, rdat[0], perr[0]});
        if (rv[1]) log1.push_back('{cyc, rdat[1], perr[1]});
    end

    task automatic drive(input bit we, input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0; req_we = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Counts cycles from reset release until each instance raises req_ready (bounded).
    task automatic wait_ready(output int n1, output int n2);
        n1 = -1; n2 = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 8) req_valid = 1'b0;
            if (n1 < 0 && rdy[0]) n1 = n;
            if (n2 < 0 && rdy[1]) n2 = n;
            if (n1 >= 0 && n2 >= 0) break;
        end
    endtask

    initial begin
        int n1, n2, acc;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        @(negedge clk);
        chk_on = 1;
        chk("rst_ready", 0, 32'(rdy), 32'(0));
        chk("rst_valid", 0, 32'(rv), 32'(0));
        chk("rst_data", 0, 32'(rdat[0]), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        // A write presented during the fill must be ignored.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 16'hFFFF; req_be = 2'b11;
        wait_ready(n1, n2);
        chk("fill_cycles", 0, 32'(n1), 32'(16));
        chk("fill_cycles", 1, 32'(n2), 32'(12));
        idle(2);

        log0.delete(); log1.delete();
        for (int a = 0; a < 16; a++) drive(0, 4'(a), 16'h0, 2'b00);
        idle(4);
        chk("zero_reads", 0, 32'(log0.size()), 32'(16));
        if (log0.size() == 16) chk("zero_addr3", 0, 32'(log0[3].d), 32'h0000);

        log0.delete(); log1.delete();
        drive(1, 4'd3, 16'hA5C3, 2'b11);
        drive(1, 4'd3, 16'h00FF, 2'b01);
        drive(0, 4'd3, 16'h0, 2'b00);
        acc = cyc;
        idle(4);
        chk("bw_count", 0, 32'(log0.size()), 32'(1));
        chk("bw_count", 1, 32'(log1.size()), 32'(1));
        if (log0.size() == 1) begin
            chk("bw_data", 0, 32'(log0[0].d), 32'hA5FF);
            chk("bw_lat", 0, 32'(log0[0].c), 32'(acc));
        end
        if (log1.size() == 1) begin
            chk("bw_data", 1, 32'(log1[0].d), 32'hA5FF);
            chk("bw_lat", 1, 32'(log1[0].c), 32'(acc + 1));
        end

        log0.delete(); log1.delete();
        drive(1, 4'd7, 16'h1234, 2'b11);
        drive(0, 4'd7, 16'h0, 2'b00);
        drive(0, 4'd7, 16'h0, 2'b00);
        drive(1, 4'd7, 16'hBEEF, 2'b11);
        drive(0, 4'd7, 16'h0, 2'b00);
        idle(4);
        chk("order_count", 0, 32'(log0.size()), 32'(3));
        if (log0.size() == 3) begin
            chk("raw_data", 0, 32'(log0[0].d), 32'h1234);
            chk("war_data", 0, 32'(log0[1].d), 32'h1234);
            chk("new_data", 0, 32'(log0[2].d), 32'hBEEF);
        end

        log0.delete(); log1.delete();
        drive(1, 4'd13, 16'h5A5A, 2'b11);
        drive(0, 4'd13, 16'h0, 2'b00);
        drive(1, 4'd0, 16'hFFFF, 2'b00);
        drive(0, 4'd0, 16'h0, 2'b00);
        idle(4);
        chk("oor_count", 1, 32'(log1.size()), 32'(2));
        if (log0.size() == 2) begin
            chk("inrange_13", 0, 32'(log0[0].d), 32'h5A5A);
            chk("be0_noop", 0, 32'(log0[1].d), 32'h0000);
        end
        if (log1.size() == 2) chk("oor_data", 1, 32'(log1[0].d), 32'h0000);

        for (int a = 0; a < 4; a++) drive(1, 4'(a), 16'(16 + a), 2'b11);
        idle(1);
        log0.delete(); log1.delete();
        drive(0, 4'd0, 16'h0, 2'b00);
        acc = cyc;
        for (int a = 1; a < 4; a++) drive(0, 4'(a), 16'h0, 2'b00);
        idle(5);
        chk("lat2_count", 1, 32'(log1.size()), 32'(4));
        if (log1.size() == 4)
            for (int k = 0; k < 4; k++) begin
                chk("lat2_cycle", 1, 32'(log1[k].c), 32'(acc + 1 + k));
                chk("lat2_data", 1, 32'(log1[k].d), 32'(16 + k));
            end

`ifdef SRAM_BYTE_PARITY_EN
        drive(1, 4'd5, 16'h0001, 2'b11);
        drive(1, 4'd6, 16'h0301, 2'b11);
        idle(1);
        dut1.g_lane[0].u_lane.mem[5] = 8'h00;
        mm[0][5] = 16'h0000;
        bad[5] = 1'b1;
        log0.delete(); log1.delete();
        drive(0, 4'd5, 16'h0, 2'b00);
        drive(0, 4'd6, 16'h0, 2'b00);
        idle(4);
        chk("perr_count", 0, 32'(log0.size()), 32'(2));
        if (log0.size() == 2) begin
            chk("perr_forced", 0, 32'(log0[0].p), 32'(1));
            chk("perr_clean", 0, 32'(log0[1].p), 32'(0));
        end
`endif

        log0.delete(); log1.delete();
        drive(0, 4'd3, 16'h0, 2'b00);
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_lat2", 1, 32'(log1.size()), 32'(0));
        wait_ready(n1, n2);
        chk("refill_cycles", 0, 32'(n1), 32'(16));
        chk("refill_cycles", 1, 32'(n2), 32'(12));
        idle(1);
        log0.delete(); log1.delete();
        drive(0, 4'd3, 16'h0, 2'b00);
        idle(4);
        chk("refill_count", 0, 32'(log0.size()), 32'(1));
        if (log0.size() == 1) chk("refill_addr3", 0, 32'(log0[0].d), 32'h0000);
        if (log1.size() == 1) chk("refill_addr3", 1, 32'(log1[0].d), 32'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
